// File: rtl/rda_pipe_adder.sv
// Fully pipelined recursive-doubling (Kogge-Stone) adder with valid/ready flow control.
// Per-bit kill/propagate/generate codes are resolved over log2(WIDTH) registered stages.
module rda_pipe_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int L = $clog2(WIDTH);

    localparam logic [1:0] KPG_K = 2'b00;
    localparam logic [1:0] KPG_P = 2'b01;
    localparam logic [1:0] KPG_G = 2'b10;

    // A propagating high element inherits the low element's status.
    function automatic logic [1:0] kpg_combine(input logic [1:0] hi, input logic [1:0] lo);
        logic [1:0] res;
        case (hi)
            KPG_P:   res = lo;
            KPG_K:   res = KPG_K;
            KPG_G:   res = KPG_G;
            default: res = KPG_K;
        endcase
        return res;
    endfunction

    logic [2*WIDTH-1:0] pf_r  [0:L];
    logic [WIDTH-1:0]   hx_r  [0:L];
    logic               cin_r [0:L];
    logic               v_r   [0:L];

    logic               out_valid_r;
    logic [WIDTH-1:0]   sum_r;
    logic               cout_r;
    logic               ovf_r;

    logic               advance_s;
    logic [2*WIDTH-1:0] kpg_s;
    logic [2*WIDTH-1:0] pf_nxt_s [1:L];
    logic [WIDTH-1:0]   carry_s;
    logic               cout_s;

    assign advance_s = out_ready | ~out_valid_r;
    assign in_ready  = advance_s;
    assign out_valid = out_valid_r;
    assign sum       = sum_r;
    assign cout      = cout_r;
    assign ovf       = ovf_r;

    // Per-bit classification; bit 0 absorbs the carry-in so the prefix needs no extra input.
    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            if (a[i] & b[i]) begin
                kpg_s[2*i +: 2] = KPG_G;
            end else if (a[i] | b[i]) begin
                kpg_s[2*i +: 2] = KPG_P;
            end else begin
                kpg_s[2*i +: 2] = KPG_K;
            end
        end
        if (kpg_s[1:0] == KPG_P) begin
            kpg_s[1:0] = cin ? KPG_G : KPG_K;
        end else begin
            kpg_s[1:0] = kpg_s[1:0];
        end
    end

    // Doubling step j combines each element with the one 2^(j-1) positions below it.
    always_comb begin
        for (int j = 1; j <= L; j++) begin
            pf_nxt_s[j] = pf_r[j-1];
            for (int i = 0; i < WIDTH; i++) begin
                if (i >= (1 << (j-1))) begin
                    pf_nxt_s[j][2*i +: 2] = kpg_combine(pf_r[j-1][2*i +: 2],
                                                        pf_r[j-1][2*(i - (1 << (j-1))) +: 2]);
                end else begin
                    pf_nxt_s[j][2*i +: 2] = pf_r[j-1][2*i +: 2];
                end
            end
        end
    end

    // Resolved prefixes are all k or g, so a generate below bit i means a carry into bit i.
    always_comb begin
        carry_s[0] = cin_r[L];
        for (int i = 1; i < WIDTH; i++) begin
            carry_s[i] = (pf_r[L][2*(i-1) +: 2] == KPG_G);
        end
        cout_s = (pf_r[L][2*(WIDTH-1) +: 2] == KPG_G);
    end

    // Pipeline registers: global stall, bubbles shift with valid data.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int j = 0; j <= L; j++) begin
                v_r[j]   <= 1'b0;
                pf_r[j]  <= {2*WIDTH{1'b0}};
                hx_r[j]  <= {WIDTH{1'b0}};
                cin_r[j] <= 1'b0;
            end
            out_valid_r <= 1'b0;
            sum_r       <= {WIDTH{1'b0}};
            cout_r      <= 1'b0;
            ovf_r       <= 1'b0;
        end else if (advance_s) begin
            v_r[0]   <= in_valid & advance_s;
            pf_r[0]  <= kpg_s;
            hx_r[0]  <= a ^ b;
            cin_r[0] <= cin;
            for (int j = 1; j <= L; j++) begin
                v_r[j]   <= v_r[j-1];
                pf_r[j]  <= pf_nxt_s[j];
                hx_r[j]  <= hx_r[j-1];
                cin_r[j] <= cin_r[j-1];
            end
            out_valid_r <= v_r[L];
            sum_r       <= hx_r[L] ^ carry_s;
            cout_r      <= cout_s;
            ovf_r       <= carry_s[WIDTH-1] ^ cout_s;
        end
    end

endmodule
